sample_mul_acc_pipe: RTL and testbench

Parametrised signed multiply / multiply-accumulate unit with a configurable pipeline depth and a valid-qualified data path. It is the next generation of the fixed 11x11, 3-stage, ce-only DSP48-style multiplier used in the sample datapath. It adds independent operand and result widths, a selectable stage count, per-sample valid tracking, and an accumulate mode with a sticky overflow flag. It sits between the HLS-scheduled operand registers and the sample accumulation logic.

---
 rtl/sample_mul_acc_pipe_if.sv | 27 ++
 rtl/sample_mul_acc_pipe.sv | 121 ++++++++++++
 tb/tb_sample_mul_acc_pipe.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sample_mul_acc_pipe_if.sv
// Operand/result bundle for sample_mul_acc_pipe. The master drives operands and
// sideband; the slave (the multiplier) returns the valid-qualified result.
interface sample_mul_acc_pipe_if #(
  parameter int DIN0_WIDTH = 11,
  parameter int DIN1_WIDTH = 11,
  parameter int DOUT_WIDTH = 11
);
  logic                         ce;
  logic                         in_valid;
  logic signed [DIN0_WIDTH-1:0] din0;
  logic signed [DIN1_WIDTH-1:0] din1;
  logic                         acc_en;
  logic                         acc_clr;
  logic                         out_valid;
  logic        [DOUT_WIDTH-1:0] dout;
  logic                         ovf;

  modport master (
    output ce, in_valid, din0, din1, acc_en, acc_clr,
    input  out_valid, dout, ovf
  );

  modport slave (
    input  ce, in_valid, din0, din1, acc_en, acc_clr,
    output out_valid, dout, ovf
  );
endinterface

// File: rtl/sample_mul_acc_pipe.sv
// Signed multiply / multiply-accumulate, NUM_STAGE ce-active cycles of latency,
// one sample per ce cycle; ce=0 freezes every register (no other backpressure).
module sample_mul_acc_pipe #(
  parameter int DIN0_WIDTH = 11,
  parameter int DIN1_WIDTH = 11,
  parameter int DOUT_WIDTH = 11,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_STAGE  = 3
) (
  input logic                  clk,
  input logic                  reset,
  sample_mul_acc_pipe_if.slave bus
);
  localparam int P_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

  typedef struct packed {
    logic vld;
    logic en;
    logic clr;
  } side_t;

  typedef struct packed {
    side_t              side;
    logic [P_WIDTH-1:0] prod;
  } prod_t;

  side_t                        s1_side;
  logic signed [DIN0_WIDTH-1:0] s1_a;
  logic signed [DIN1_WIDTH-1:0] s1_b;
  logic signed [P_WIDTH-1:0]    mul;
  prod_t                        mul_word;
  prod_t                        last_word;

  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic                         add_ovf;

  logic                         out_valid_q;
  logic        [DOUT_WIDTH-1:0] dout_q;
  logic                         ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_side <= '0;
      s1_a    <= '0;
      s1_b    <= '0;
    end else if (bus.ce) begin
      s1_side <= '{vld: bus.in_valid, en: bus.acc_en, clr: bus.acc_clr};
      s1_a    <= bus.din0;
      s1_b    <= bus.din1;
    end
  end

  assign mul      = s1_a * s1_b;
  assign mul_word = '{side: s1_side, prod: mul};

  // With two stages the product feeds the accumulate register combinationally.
  generate
    if (NUM_STAGE == 2) begin : g_direct
      assign last_word = mul_word;
    end else begin : g_pipe
      localparam int NPROD = NUM_STAGE - 2;
      prod_t pipe [NPROD];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < NPROD; i++) pipe[i] <= '0;
        end else if (bus.ce) begin
          pipe[0] <= mul_word;
          for (int i = 1; i < NPROD; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign last_word = pipe[NPROD-1];
    end
  endgenerate

  assign prod_ext = ACC_WIDTH'($signed(last_word.prod));
  assign acc_sum  = acc + prod_ext;
  assign add_ovf  = (acc[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                    (acc_sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);

  // Bubbles only clear out_valid; dout, acc and ovf keep their last values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
      acc         <= '0;
    end else if (bus.ce) begin
      out_valid_q <= last_word.side.vld;
      if (last_word.side.vld) begin
        case ({last_word.side.en, last_word.side.clr})
          2'b00: begin
            dout_q <= prod_ext[DOUT_WIDTH-1:0];
          end
          2'b01: begin
            dout_q <= prod_ext[DOUT_WIDTH-1:0];
            acc    <= '0;
            ovf_q  <= 1'b0;
          end
          2'b11: begin
            dout_q <= prod_ext[DOUT_WIDTH-1:0];
            acc    <= prod_ext;
            ovf_q  <= 1'b0;
          end
          default: begin
            dout_q <= acc_sum[DOUT_WIDTH-1:0];
            acc    <= acc_sum;
            ovf_q  <= ovf_q | add_ovf;
          end
        endcase
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_sample_mul_acc_pipe.sv
// Directed bench: dut_a uses the default 3-stage/32-bit configuration,
// dut_b a 2-stage/22-bit accumulator to reach signed overflow.
module tb_sample_mul_acc_pipe;
  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  sample_mul_acc_pipe_if #(.DIN0_WIDTH(11), .DIN1_WIDTH(11), .DOUT_WIDTH(11)) ia ();
  sample_mul_acc_pipe_if #(.DIN0_WIDTH(11), .DIN1_WIDTH(11), .DOUT_WIDTH(11)) ib ();

  sample_mul_acc_pipe #(
    .DIN0_WIDTH(11), .DIN1_WIDTH(11), .DOUT_WIDTH(11), .ACC_WIDTH(32), .NUM_STAGE(3)
  ) dut_a (.clk(clk), .reset(reset), .bus(ia));

  sample_mul_acc_pipe #(
    .DIN0_WIDTH(11), .DIN1_WIDTH(11), .DOUT_WIDTH(11), .ACC_WIDTH(22), .NUM_STAGE(2)
  ) dut_b (.clk(clk), .reset(reset), .bus(ib));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_a(input logic v, input int a, input int b, input logic en, input logic clr);
    ia.in_valid = v;
    ia.din0     = 11'(a);
    ia.din1     = 11'(b);
    ia.acc_en   = en;
    ia.acc_clr  = clr;
  endtask

  task automatic drive_b(input logic v, input int a, input int b, input logic en, input logic clr);
    ib.in_valid = v;
    ib.din0     = 11'(a);
    ib.din1     = 11'(b);
    ib.acc_en   = en;
    ib.acc_clr  = clr;
  endtask

  task automatic test_reset();
    #1;
    total++; if (ia.out_valid !== 1'b0) $display("FAIL rst_a_ov got=%b exp=0", ia.out_valid); else passed++;
    total++; if (ia.dout !== 11'h000) $display("FAIL rst_a_dout got=%h exp=000", ia.dout); else passed++;
    total++; if (ia.ovf !== 1'b0) $display("FAIL rst_a_ovf got=%b exp=0", ia.ovf); else passed++;
    total++; if (ib.out_valid !== 1'b0) $display("FAIL rst_b_ov got=%b exp=0", ib.out_valid); else passed++;
    total++; if (ib.dout !== 11'h000) $display("FAIL rst_b_dout got=%h exp=000", ib.dout); else passed++;
    total++; if (ib.ovf !== 1'b0) $display("FAIL rst_b_ovf got=%b exp=0", ib.ovf); else passed++;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_passthru();
    drive_a(1, 3, -5, 0, 0);
    tick();
    drive_a(0, 0, 0, 0, 0);
    total++; if (ia.out_valid !== 1'b0) $display("FAIL pass_ov_e1 got=%b exp=0", ia.out_valid); else passed++;
    tick();
    total++; if (ia.out_valid !== 1'b0) $display("FAIL pass_ov_e2 got=%b exp=0", ia.out_valid); else passed++;
    tick();
    total++; if (ia.out_valid !== 1'b1) $display("FAIL pass_ov_e3 got=%b exp=1", ia.out_valid); else passed++;
    total++; if (ia.dout !== 11'h7F1) $display("FAIL pass_dout got=%h exp=7f1", ia.dout); else passed++;
    total++; if (ia.ovf !== 1'b0) $display("FAIL pass_ovf got=%b exp=0", ia.ovf); else passed++;
    tick();
    total++; if (ia.out_valid !== 1'b0) $display("FAIL pass_ov_e4 got=%b exp=0", ia.out_valid); else passed++;
    total++; if (ia.dout !== 11'h7F1) $display("FAIL pass_hold got=%h exp=7f1", ia.dout); else passed++;
  endtask

  task automatic test_truncation();
    drive_a(1, 100, 100, 0, 0);
    tick();
    drive_a(1, 0, 0, 1, 0);
    tick();
    drive_a(0, 0, 0, 0, 0);
    tick();
    total++; if (ia.out_valid !== 1'b1) $display("FAIL trunc_ov got=%b exp=1", ia.out_valid); else passed++;
    total++; if (ia.dout !== 11'h710) $display("FAIL trunc_dout got=%h exp=710", ia.dout); else passed++;
    tick();
    total++; if (ia.out_valid !== 1'b1) $display("FAIL trunc_acc_ov got=%b exp=1", ia.out_valid); else passed++;
    total++; if (ia.dout !== 11'h000) $display("FAIL trunc_acc_untouched got=%h exp=000", ia.dout); else passed++;
    total++; if (ia.ovf !== 1'b0) $display("FAIL trunc_ovf got=%b exp=0", ia.ovf); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    drive_a(1, 2, 3, 1, 1);
    tick();
    drive_a(1, 4, 5, 1, 0);
    tick();
    drive_a(1, -1, 6, 1, 0);
    tick();
    drive_a(0, 0, 0, 0, 0);
    total++; if (ia.out_valid !== 1'b1 || ia.dout !== 11'd6)
      $display("FAIL b2b_r0 got=%b/%0d exp=1/6", ia.out_valid, ia.dout); else passed++;
    tick();
    total++; if (ia.out_valid !== 1'b1 || ia.dout !== 11'd26)
      $display("FAIL b2b_r1 got=%b/%0d exp=1/26", ia.out_valid, ia.dout); else passed++;
    tick();
    total++; if (ia.out_valid !== 1'b1 || ia.dout !== 11'd20)
      $display("FAIL b2b_r2 got=%b/%0d exp=1/20", ia.out_valid, ia.dout); else passed++;
    tick();
    total++; if (ia.out_valid !== 1'b0 || ia.dout !== 11'd20)
      $display("FAIL b2b_tail got=%b/%0d exp=0/20", ia.out_valid, ia.dout); else passed++;
  endtask

  task automatic test_stall();
    drive_a(1, 2, 3, 1, 1);
    tick();
    drive_a(1, 4, 5, 1, 0);
    tick();
    ia.ce = 1'b0;
    drive_a(1, 7, 7, 1, 0);  // must be ignored while ce=0
    tick();
    total++; if (ia.out_valid !== 1'b0 || ia.dout !== 11'd20)
      $display("FAIL stall_c0 got=%b/%0d exp=0/20", ia.out_valid, ia.dout); else passed++;
    tick();
    total++; if (ia.out_valid !== 1'b0 || ia.dout !== 11'd20)
      $display("FAIL stall_c1 got=%b/%0d exp=0/20", ia.out_valid, ia.dout); else passed++;
    ia.ce = 1'b1;
    drive_a(1, -1, 6, 1, 0);
    tick();
    drive_a(0, 0, 0, 0, 0);
    total++; if (ia.out_valid !== 1'b1 || ia.dout !== 11'd6)
      $display("FAIL stall_r0 got=%b/%0d exp=1/6", ia.out_valid, ia.dout); else passed++;
    tick();
    total++; if (ia.out_valid !== 1'b1 || ia.dout !== 11'd26)
      $display("FAIL stall_r1 got=%b/%0d exp=1/26", ia.out_valid, ia.dout); else passed++;
    tick();
    total++; if (ia.out_valid !== 1'b1 || ia.dout !== 11'd20)
      $display("FAIL stall_r2 got=%b/%0d exp=1/20", ia.out_valid, ia.dout); else passed++;
    tick();
    total++; if (ia.out_valid !== 1'b0 || ia.dout !== 11'd20)
      $display("FAIL stall_dup got=%b/%0d exp=0/20", ia.out_valid, ia.dout); else passed++;
    tick();
    total++; if (ia.out_valid !== 1'b0) $display("FAIL stall_dup2 got=%b exp=0", ia.out_valid); else passed++;
  endtask

  task automatic test_overflow();
    drive_b(1, -1024, -1024, 1, 1);
    tick();
    total++; if (ib.out_valid !== 1'b0) $display("FAIL ovf_lat got=%b exp=0", ib.out_valid); else passed++;
    drive_b(1, -1024, -1024, 1, 0);
    tick();
    total++; if (ib.out_valid !== 1'b1 || ib.dout !== 11'h000 || ib.ovf !== 1'b0)
      $display("FAIL ovf_r0 got=%b/%h/%b exp=1/000/0", ib.out_valid, ib.dout, ib.ovf); else passed++;
    drive_b(1, 0, 0, 1, 0);
    tick();
    total++; if (ib.out_valid !== 1'b1 || ib.dout !== 11'h000 || ib.ovf !== 1'b1)
      $display("FAIL ovf_wrap got=%b/%h/%b exp=1/000/1", ib.out_valid, ib.dout, ib.ovf); else passed++;
    drive_b(1, 1, 2, 0, 1);
    tick();
    total++; if (ib.out_valid !== 1'b1 || ib.ovf !== 1'b1)
      $display("FAIL ovf_sticky got=%b/%b exp=1/1", ib.out_valid, ib.ovf); else passed++;
    drive_b(0, 0, 0, 0, 0);
    tick();
    total++; if (ib.out_valid !== 1'b1 || ib.dout !== 11'd2 || ib.ovf !== 1'b0)
      $display("FAIL ovf_clr got=%b/%0d/%b exp=1/2/0", ib.out_valid, ib.dout, ib.ovf); else passed++;
    tick();
    total++; if (ib.out_valid !== 1'b0 || ib.dout !== 11'd2)
      $display("FAIL ovf_tail got=%b/%0d exp=0/2", ib.out_valid, ib.dout); else passed++;
  endtask

  task automatic test_reset_midflight();
    drive_a(1, 5, 5, 0, 0);
    drive_b(1, -1024, -1024, 1, 1);
    tick();
    drive_a(1, 6, 6, 0, 0);
    drive_b(1, -1024, -1024, 1, 0);
    tick();
    drive_a(1, 7, 7, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    tick();
    drive_a(1, 8, 8, 0, 0);
    total++; if (ia.out_valid !== 1'b1 || ia.dout !== 11'd25)
      $display("FAIL mid_pre_a got=%b/%0d exp=1/25", ia.out_valid, ia.dout); else passed++;
    total++; if (ib.ovf !== 1'b1) $display("FAIL mid_pre_b_ovf got=%b exp=1", ib.ovf); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (ia.out_valid !== 1'b0 || ia.dout !== 11'd0 || ia.ovf !== 1'b0)
      $display("FAIL mid_async_a got=%b/%0d/%b exp=0/0/0", ia.out_valid, ia.dout, ia.ovf); else passed++;
    total++; if (ib.out_valid !== 1'b0 || ib.dout !== 11'd0 || ib.ovf !== 1'b0)
      $display("FAIL mid_async_b got=%b/%0d/%b exp=0/0/0", ib.out_valid, ib.dout, ib.ovf); else passed++;
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (ia.out_valid !== 1'b0) $display("FAIL mid_flush_a cyc=%0d got=%b exp=0", i, ia.out_valid); else passed++;
      total++; if (ib.out_valid !== 1'b0) $display("FAIL mid_flush_b cyc=%0d got=%b exp=0", i, ib.out_valid); else passed++;
    end
  endtask

  initial begin
    reset = 1'b1;
    ia.ce = 1'b1;
    ib.ce = 1'b1;
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    test_reset();
    test_passthru();
    test_truncation();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
